// File: rtl/mem_arbiter.sv
// Two-requester (CPU data port / debug loader) arbiter in front of a single-port RAM.
// Each access is IDLE/RESP -> ACCESS -> RESP; arbitration is round-robin or CPU-first.
module mem_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ready,
    output logic [31:0] dbg_rdata,

    output logic        gnt_cpu,
    output logic        gnt_dbg,

    output logic        mem_wr_sig,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam bit CPU_FIRST = (FIXED_PRIO != 0);

    state_t      state_q, state_d;
    logic        gnt_cpu_q, gnt_cpu_d;
    logic        gnt_dbg_q, gnt_dbg_d;
    logic        last_dbg_q, last_dbg_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        dbg_ready_q, dbg_ready_d;
    logic        mem_wr_sig_q, mem_wr_sig_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wr_data_q, mem_wr_data_d;
    logic        start;
    logic        pick_dbg;

    always_comb begin
        state_d       = state_q;
        gnt_cpu_d     = gnt_cpu_q;
        gnt_dbg_d     = gnt_dbg_q;
        last_dbg_d    = last_dbg_q;
        cpu_ready_d   = 1'b0;
        dbg_ready_d   = 1'b0;
        mem_wr_sig_d  = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        start         = 1'b0;
        pick_dbg      = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_cpu_d = 1'b0;
                gnt_dbg_d = 1'b0;
                if (cpu_req || dbg_req) begin
                    start = 1'b1;
                    if (cpu_req && dbg_req) begin
                        pick_dbg = CPU_FIRST ? 1'b0 : !last_dbg_q;
                    end else begin
                        pick_dbg = dbg_req;
                    end
                end
            end
            ACCESS: begin
                state_d     = RESP;
                cpu_ready_d = gnt_cpu_q;
                dbg_ready_d = gnt_dbg_q;
            end
            RESP: begin
                state_d   = IDLE;
                gnt_cpu_d = 1'b0;
                gnt_dbg_d = 1'b0;
                // The port just served is masked; a CPU-first arbiter still refuses dbg while cpu_req is up.
                if (gnt_cpu_q) begin
                    if (dbg_req && (!CPU_FIRST || !cpu_req)) begin
                        start    = 1'b1;
                        pick_dbg = 1'b1;
                    end
                end else if (cpu_req) begin
                    start    = 1'b1;
                    pick_dbg = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_cpu_d = 1'b0;
                gnt_dbg_d = 1'b0;
            end
        endcase

        if (start) begin
            state_d       = ACCESS;
            gnt_cpu_d     = !pick_dbg;
            gnt_dbg_d     = pick_dbg;
            last_dbg_d    = pick_dbg;
            mem_wr_sig_d  = pick_dbg ? dbg_we    : cpu_we;
            mem_addr_d    = pick_dbg ? dbg_addr  : cpu_addr;
            mem_wr_data_d = pick_dbg ? dbg_wdata : cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            gnt_cpu_q     <= 1'b0;
            gnt_dbg_q     <= 1'b0;
            last_dbg_q    <= 1'b1;
            cpu_ready_q   <= 1'b0;
            dbg_ready_q   <= 1'b0;
            mem_wr_sig_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            gnt_cpu_q     <= gnt_cpu_d;
            gnt_dbg_q     <= gnt_dbg_d;
            last_dbg_q    <= last_dbg_d;
            cpu_ready_q   <= cpu_ready_d;
            dbg_ready_q   <= dbg_ready_d;
            mem_wr_sig_q  <= mem_wr_sig_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign gnt_cpu     = gnt_cpu_q;
    assign gnt_dbg     = gnt_dbg_q;
    assign cpu_ready   = cpu_ready_q;
    assign dbg_ready   = dbg_ready_q;
    assign mem_wr_sig  = mem_wr_sig_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;

    // RAM data arrives in RESP, the same cycle ready is high, so it is gated rather than registered.
    assign cpu_rdata   = cpu_ready_q ? mem_rd_data : '0;
    assign dbg_rdata   = dbg_ready_q ? mem_rd_data : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 means the CPU port wins every tie.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cpu_req, input, 1 bit: CPU data-port access request.
REQ-005 SHALL have port cpu_we, input, 1 bit: CPU write (1) or read (0).
REQ-006 SHALL have port cpu_addr, input, 32 bits: CPU byte address.
REQ-007 SHALL have port cpu_wdata, input, 32 bits: CPU write data.
REQ-008 SHALL have port cpu_ready, output, 1 bit: one-cycle completion pulse to the CPU.
REQ-009 SHALL have port cpu_rdata, output, 32 bits: CPU read data, valid while cpu_ready=1.
REQ-010 SHALL have ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ready and dbg_rdata: the same widths and meanings as the cpu_* ports, for the debug/loader requester.
REQ-011 SHALL have port gnt_cpu, output, 1 bit: CPU owns the RAM.
REQ-012 SHALL have port gnt_dbg, output, 1 bit: debug port owns the RAM.
REQ-013 SHALL have port mem_wr_sig, output, 1 bit: RAM write strobe.
REQ-014 SHALL have port mem_addr, output, 32 bits: RAM address.
REQ-015 SHALL have port mem_wr_data, output, 32 bits: RAM write data.
REQ-016 SHALL have port mem_rd_data, input, 32 bits: RAM read data, valid one cycle after the address is sampled.

Function
REQ-017 SHALL implement an FSM with exactly three states, IDLE, ACCESS and RESP.
REQ-018 In IDLE with no request pending, the FSM SHALL stay in IDLE.
REQ-019 In IDLE with any request pending, the FSM SHALL arbitrate, latch the winner's we/addr/wdata and go to ACCESS.
REQ-020 ACCESS SHALL always go to RESP after one cycle.
REQ-021 From RESP, the FSM SHALL go to ACCESS if the other port requests (the just-served port is masked), otherwise to IDLE.
REQ-022 gnt_cpu and gnt_dbg SHALL be registered, one-hot or zero, and high throughout ACCESS and RESP of the owned transaction.
REQ-023 During ACCESS, mem_addr and mem_wr_data SHALL carry the latched values, and mem_wr_sig SHALL equal the latched we; mem_wr_sig SHALL be 0 in every other state.
REQ-024 x_ready SHALL be registered and high only during RESP for the granted port.
REQ-025 x_rdata SHALL equal mem_rd_data while x_ready=1, else 0; writes also pulse ready, with rdata don't-care.
REQ-026 Latency: request sampled in IDLE at edge N -> ACCESS in cycle N+1 -> ready in cycle N+2.
REQ-027 Under continuous contention, throughput SHALL be one transaction per 2 cycles.
REQ-028 Round-robin (FIXED_PRIO=0): on a simultaneous request, the port not served last SHALL win; a last_served flag SHALL update at each IDLE/RESP->ACCESS transition.
REQ-029 FIXED_PRIO=1: the CPU SHALL win every tie; the debug port is served only when cpu_req=0 at an arbitration point.
REQ-030 A requester SHALL hold req/we/addr/wdata stable until it sees ready, and SHALL drop req in the cycle after ready for a single access.
REQ-031 A req still high one cycle after ready SHALL be treated as a new transaction.
REQ-032 Input changes during ACCESS/RESP SHALL NOT alter the in-flight transaction, because the values are latched.
REQ-033 A request on the non-granted port SHALL wait without loss, with no timeout.
REQ-034 Under round-robin, worst-case wait SHALL be one transaction of the other port.

Reset
REQ-035 reset_n=0 SHALL immediately force state=IDLE, gnt_*=0, x_ready=0, x_rdata=0, mem_wr_sig=0, mem_addr=0, mem_wr_data=0, and last_served=dbg (CPU wins the first tie).
REQ-036 A reset asserted during ACCESS SHALL abort the write (mem_wr_sig drops asynchronously), and no ready SHALL be issued for the aborted transaction.
REQ-037 After release, the first arbitration SHALL occur at the first rising edge with reset_n=1.

Verification
REQ-038 Single write: dbg write addr=0x10, wdata=0x37 -> mem_wr_sig=1 for exactly 1 cycle with mem_addr=0x10, then dbg_ready pulse 2 cycles after req.
REQ-039 Read-back: cpu read addr=0x10 after REQ-038 -> cpu_ready with cpu_rdata=0x37 2 cycles after req; dbg_ready stays 0.
REQ-040 Simultaneous requests after reset, FIXED_PRIO=0, both held -> grant order CPU, DBG, CPU, DBG; ready pulses every 2 cycles.
REQ-041 Repeat REQ-040 with FIXED_PRIO=1, CPU re-requesting every transaction -> dbg never granted; dbg granted on the first arbitration after cpu_req=0.
REQ-042 reset_n=0 mid-ACCESS of a cpu write to 0x20 with wdata=0x55 -> mem_wr_sig, gnt_cpu and cpu_ready all 0 at once; after release, RAM[0x20] unchanged.
REQ-043 Fibonacci program, CPU alone through the arbiter with dbg idle, 500-cycle budget -> x3=55 (the program needs no extra ready stalls).
